// File: rtl/motor_pasos_pkg.sv
// Shared definitions for the stepper sequencer: coil tables, phase width, command encoding.
// Build option: MOTOR_HALF_STEP_EN selects the 8-entry half-step table and a 3-bit phase index.
package motor_pkg;

  localparam int unsigned COIL_W = 4;
  localparam int unsigned DEG_W  = 16;
  localparam int unsigned SUB_W  = 8;

`ifdef MOTOR_HALF_STEP_EN
  localparam int unsigned PHASE_W = 3;
`else
  localparam int unsigned PHASE_W = 2;
`endif

  localparam logic [1:0] CMD_ON = 2'b01;

  // Entry k sits at bits [4k+3:4k]; bit 3 of each entry is coil A.
  localparam logic [15:0] FULL_TABLE = {4'b1001, 4'b0011, 4'b0110, 4'b1100};
  localparam logic [31:0] HALF_TABLE = {4'b1001, 4'b0001, 4'b0011, 4'b0010,
                                        4'b0110, 4'b0100, 4'b1100, 4'b1000};

  function automatic logic [COIL_W-1:0] coil_of(input logic [PHASE_W-1:0] phase);
`ifdef MOTOR_HALF_STEP_EN
    return HALF_TABLE[{phase, 2'b00} +: COIL_W];
`else
    return FULL_TABLE[{phase, 2'b00} +: COIL_W];
`endif
  endfunction

  function automatic int unsigned tick_period(input int unsigned clk_hz,
                                              input int unsigned step_hz);
    return (step_hz == 0 || clk_hz < step_hz) ? 1 : clk_hz / step_hz;
  endfunction

endpackage

// File: rtl/motor_pasos_if.sv
// Command/drive bundle between the positioning controller and the stepper sequencer.
interface motor_pasos_if;
  logic [1:0]  cmd_theta_pos;
  logic [1:0]  cmd_theta_neg;
  logic [1:0]  cmd_phi_pos;
  logic [1:0]  cmd_phi_neg;
  logic [3:0]  coil_theta;
  logic [3:0]  coil_phi;
  logic [15:0] theta_actual;
  logic [15:0] phi_actual;
  logic        step_theta;
  logic        step_phi;

  modport master (
    output cmd_theta_pos, cmd_theta_neg, cmd_phi_pos, cmd_phi_neg,
    input  coil_theta, coil_phi, theta_actual, phi_actual, step_theta, step_phi
  );

  modport slave (
    input  cmd_theta_pos, cmd_theta_neg, cmd_phi_pos, cmd_phi_neg,
    output coil_theta, coil_phi, theta_actual, phi_actual, step_theta, step_phi
  );
endinterface

// File: rtl/motor_pasos_step_axis.sv
// One stepper axis: phase sequencing, sub-degree counting and degree position
// with either clamping (WRAP=0, 0..LIMIT) or modulo (WRAP=1, 0..LIMIT-1) behaviour.
module step_axis
  import motor_pkg::*;
#(
  parameter int unsigned LIMIT         = 180,
  parameter bit          WRAP          = 1'b0,
  parameter int unsigned STEPS_PER_DEG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_i,
  input  logic [1:0]        pos_i,
  input  logic [1:0]        neg_i,
  output logic [COIL_W-1:0] coil_o,
  output logic [DEG_W-1:0]  deg_o,
  output logic              step_o
);

  localparam logic [SUB_W-1:0] SUB_TOP = SUB_W'(STEPS_PER_DEG - 1);
  localparam logic [DEG_W-1:0] DEG_TOP = WRAP ? DEG_W'(LIMIT - 1) : DEG_W'(LIMIT);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic [DEG_W-1:0]   deg_q, deg_d;
  logic [COIL_W-1:0]  coil_q, coil_d;
  logic               step_q, step_d;
  logic               pos_act, neg_act, at_min, at_max, cw, ccw;

  // Step decision: exclusive command on a tick, clamped axes refuse to leave their range.
  always_comb begin
    pos_act = (pos_i == CMD_ON);
    neg_act = (neg_i == CMD_ON);
    at_min  = !WRAP && (deg_q == '0) && (sub_q == '0);
    at_max  = !WRAP && (deg_q == DEG_TOP) && (sub_q == '0);
    cw      = tick_i && pos_act && !neg_act && !at_min;
    ccw     = tick_i && neg_act && !pos_act && !at_max;
  end

  always_comb begin
    phase_d = phase_q;
    sub_d   = sub_q;
    deg_d   = deg_q;
    coil_d  = coil_q;
    step_d  = cw || ccw;
    if (ccw) begin
      phase_d = phase_q + PHASE_W'(1);
      if (sub_q == SUB_TOP) begin
        sub_d = '0;
        deg_d = (deg_q == DEG_TOP) ? '0 : deg_q + DEG_W'(1);
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end else if (cw) begin
      phase_d = phase_q - PHASE_W'(1);
      if (sub_q == '0) begin
        sub_d = SUB_TOP;
        deg_d = (deg_q == '0) ? DEG_TOP : deg_q - DEG_W'(1);
      end else begin
        sub_d = sub_q - SUB_W'(1);
      end
    end
    // Coils stay de-energized until the first step, then hold the last pattern.
    if (cw || ccw) coil_d = coil_of(phase_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      sub_q   <= '0;
      deg_q   <= '0;
      coil_q  <= '0;
      step_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      sub_q   <= sub_d;
      deg_q   <= deg_d;
      coil_q  <= coil_d;
      step_q  <= step_d;
    end
  end

  assign coil_o = coil_q;
  assign deg_o  = deg_q;
  assign step_o = step_q;

endmodule

// File: rtl/motor_pasos.sv
// Two-axis stepper sequencer: shared step-rate prescaler feeding theta (clamped) and phi (wrapping) axes.
// Build option: MOTOR_HALF_STEP_EN (half-step coil sequence, see motor_pkg).
module motor_pasos
  import motor_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned STEP_HZ       = 200,
  parameter int unsigned STEPS_PER_DEG = 4,
  parameter int unsigned THETA_MAX     = 180,
  parameter int unsigned PHI_MOD       = 360
) (
  input  logic         clk,
  input  logic         rst,
  motor_pasos_if.slave bus
);

  localparam int unsigned TICK_N = tick_period(CLK_HZ, STEP_HZ);
  localparam int unsigned CNT_W  = (TICK_N > 1) ? $clog2(TICK_N) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_c;

  // Prescaler: tick on the last count of each step period.
  always_comb begin
    tick_c = (cnt_q == CNT_W'(TICK_N - 1));
    cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  step_axis #(
    .LIMIT         (THETA_MAX),
    .WRAP          (1'b0),
    .STEPS_PER_DEG (STEPS_PER_DEG)
  ) u_theta (
    .clk    (clk),
    .rst    (rst),
    .tick_i (tick_c),
    .pos_i  (bus.cmd_theta_pos),
    .neg_i  (bus.cmd_theta_neg),
    .coil_o (bus.coil_theta),
    .deg_o  (bus.theta_actual),
    .step_o (bus.step_theta)
  );

  step_axis #(
    .LIMIT         (PHI_MOD),
    .WRAP          (1'b1),
    .STEPS_PER_DEG (STEPS_PER_DEG)
  ) u_phi (
    .clk    (clk),
    .rst    (rst),
    .tick_i (tick_c),
    .pos_i  (bus.cmd_phi_pos),
    .neg_i  (bus.cmd_phi_neg),
    .coil_o (bus.coil_phi),
    .deg_o  (bus.phi_actual),
    .step_o (bus.step_phi)
  );

endmodule
